// File: rtl/gvp_ng_pkg.sv
// Shared types and program-word layout for the gvp_ng vector program player.
package gvp_ng_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HDR,
    S_STEP,
    S_DATA,
    S_DONE
  } state_e;

  localparam int unsigned HDR_W    = 160;
  localparam int unsigned FLD_W    = 32;
  localparam int unsigned N_LSB    = 0;
  localparam int unsigned IIN_LSB  = 32;
  localparam int unsigned DECI_LSB = 64;
  localparam int unsigned OPT_LSB  = 96;
  localparam int unsigned NREP_LSB = 128;
  localparam int unsigned NREP_W   = 16;
  localparam int unsigned NEXT_LSB = 144;
  localparam int unsigned NEXT_W   = 8;

  localparam logic STORE_HDR  = 1'b1;
  localparam logic STORE_DATA = 1'b0;

  function automatic logic [FLD_W-1:0] max1(input logic [FLD_W-1:0] v);
    return (v == '0) ? FLD_W'(1) : v;
  endfunction

endpackage

// File: rtl/gvp_ng_if.sv
// Program-write bus and store handshake between gvp_ng and its host.
interface gvp_ng_if
  import gvp_ng_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned NUM_VECTORS_N2 = 3,
  parameter int unsigned DW             = 32
);
  localparam int unsigned PW = HDR_W + NUM_CH * DW;

  logic                      prog_we;
  logic [NUM_VECTORS_N2-1:0] prog_addr;
  logic [PW-1:0]             prog_data;
  logic                      store_valid;
  logic                      store_ready;
  logic                      store_kind;
  logic [NUM_CH*DW-1:0]      pos;

  modport master (
    output prog_we, prog_addr, prog_data, store_ready,
    input  store_valid, store_kind, pos
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, store_ready,
    output store_valid, store_kind, pos
  );
endinterface

// File: rtl/gvp_ng_chan.sv
// One channel: DW-bit signed accumulator with saturation and sticky clip flag.
module gvp_ng_chan #(
  parameter int unsigned DW = 32
) (
  input  logic          a_clk,
  input  logic          a_resetn,
  input  logic          clr_i,
  input  logic          sat_clr_i,
  input  logic          en_i,
  input  logic [DW-1:0] delta_i,
  output logic [DW-1:0] pos_o,
  output logic          sat_o
);
  logic [DW-1:0] pos_q, pos_d;
  logic          sat_q;
  logic [DW:0]   sum;
  logic          ovf;

  // One guard bit: overflow when the two top bits of the extended sum differ.
  assign sum = {pos_q[DW-1], pos_q} + {delta_i[DW-1], delta_i};
  assign ovf = sum[DW] ^ sum[DW-1];

  always_comb begin
    pos_d = sum[DW-1:0];
    if (ovf) pos_d = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      pos_q <= '0;
      sat_q <= 1'b0;
    end else begin
      if (clr_i)     pos_q <= '0;
      else if (en_i) pos_q <= pos_d;
      if (sat_clr_i)        sat_q <= 1'b0;
      else if (en_i && ovf) sat_q <= 1'b1;
    end
  end

  assign pos_o = pos_q;
  assign sat_o = sat_q;
endmodule

// File: rtl/gvp_ng.sv
// Vector program player: steps NUM_CH positions through programmed sections,
// emitting header/data stores and looping via per-vector repeat counters.
module gvp_ng
  import gvp_ng_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned NUM_VECTORS_N2 = 3,
  parameter int unsigned DW             = 32
) (
  input  logic              a_clk,
  input  logic              a_resetn,
  gvp_ng_if.slave           bus,
  input  logic              run,
  input  logic              pause,
  input  logic              pos_clr,
  output logic [31:0]       options,
  output logic [31:0]       section,
  output logic              busy,
  output logic              finished,
  output logic              prog_err,
  output logic [NUM_CH-1:0] sat
);
  localparam int unsigned PW    = HDR_W + NUM_CH * DW;
  localparam int unsigned DEPTH = 1 << NUM_VECTORS_N2;

  logic [PW-1:0]             mem_q [DEPTH];
  logic [NREP_W-1:0]         lc_q  [DEPTH];
  state_e                    state_q, state_d;
  logic [NUM_VECTORS_N2-1:0] pvc_q;
  logic [31:0]               sec_q, opt_q, i_q, ii_q, div_q, cnt_q;
  logic                      prog_err_q;

  logic [PW-1:0]     cur;
  logic [31:0]       cur_n, cur_iin, cur_deci, cur_opt;
  logic [NREP_W-1:0] cur_nrep;
  logic [NEXT_W-1:0] cur_next;
  logic              start, hs, tick, hold, add, sec_end, can_write;
  logic [NUM_CH*DW-1:0] pos_w;
  logic              unused_bits;

  // Memory is frozen while busy, so the active vector is read straight from it.
  assign cur      = mem_q[pvc_q];
  assign cur_n    = cur[N_LSB    +: FLD_W];
  assign cur_iin  = cur[IIN_LSB  +: FLD_W];
  assign cur_deci = cur[DECI_LSB +: FLD_W];
  assign cur_opt  = cur[OPT_LSB  +: FLD_W];
  assign cur_nrep = cur[NREP_LSB +: NREP_W];
  assign cur_next = cur[NEXT_LSB +: NEXT_W];
  assign unused_bits = ^{cur[HDR_W-1 -: 8], cur_next};

  assign busy      = (state_q == S_LOAD) || (state_q == S_HDR) ||
                     (state_q == S_STEP) || (state_q == S_DATA);
  assign can_write = (state_q == S_IDLE) || (state_q == S_DONE);
  assign start     = (state_q == S_IDLE) && run;
  assign hs        = bus.store_valid && bus.store_ready;
  assign tick      = (state_q == S_STEP) && run && (cnt_q == div_q - 32'd1);
  assign hold      = (ii_q == '0) && pause;
  assign add       = tick && !hold;
  assign sec_end   = (state_q == S_DATA) && run && hs && !(i_q > 32'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_LOAD;
      S_LOAD: state_d = (cur_n == '0) ? S_DONE : S_HDR;
      S_HDR:  if (hs) state_d = S_STEP;
      S_STEP: if (add && (ii_q == '0)) state_d = S_DATA;
      S_DATA: if (hs) state_d = (i_q > 32'd1) ? S_STEP : S_LOAD;
      S_DONE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && !run) state_d = S_IDLE;
  end

  always_ff @(posedge a_clk or negedge a_resetn) begin
    if (!a_resetn) begin
      state_q    <= S_IDLE;
      pvc_q      <= '0;
      sec_q      <= '0;
      opt_q      <= '0;
      i_q        <= '0;
      ii_q       <= '0;
      div_q      <= 32'd1;
      cnt_q      <= '0;
      prog_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prog_err_q <= bus.prog_we && !can_write;
      if (start) begin
        pvc_q <= '0;
        sec_q <= '0;
      end
      if ((state_q == S_LOAD) && run) begin
        i_q   <= cur_n;
        ii_q  <= cur_iin;
        div_q <= max1(cur_deci);
        opt_q <= cur_opt;
      end
      // A held data point keeps the divider parked on its tick value.
      if ((state_d == S_STEP) && (state_q != S_STEP)) cnt_q <= '0;
      else if (state_q == S_STEP) begin
        if (!tick)      cnt_q <= cnt_q + 32'd1;
        else if (!hold) cnt_q <= '0;
      end
      if (add && (ii_q != '0)) ii_q <= ii_q - 32'd1;
      if ((state_q == S_DATA) && run && hs && (i_q > 32'd1)) begin
        i_q  <= i_q - 32'd1;
        ii_q <= cur_iin;
      end
      if (sec_end) begin
        sec_q <= sec_q + 32'd1;
        pvc_q <= (lc_q[pvc_q] != '0) ? pvc_q + cur_next[NUM_VECTORS_N2-1:0]
                                     : pvc_q + NUM_VECTORS_N2'(1);
      end
    end
  end

  always_ff @(posedge a_clk) begin
    if (bus.prog_we && can_write) mem_q[bus.prog_addr] <= bus.prog_data;
    if (start) begin
      for (int unsigned v = 0; v < DEPTH; v++) lc_q[v] <= mem_q[v][NREP_LSB +: NREP_W];
    end else if (sec_end) begin
      lc_q[pvc_q] <= (lc_q[pvc_q] != '0) ? lc_q[pvc_q] - NREP_W'(1) : cur_nrep;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    gvp_ng_chan #(.DW(DW)) u_chan (
      .a_clk     (a_clk),
      .a_resetn  (a_resetn),
      .clr_i     (pos_clr && (state_q == S_IDLE)),
      .sat_clr_i (start),
      .en_i      (add),
      .delta_i   (cur[HDR_W + c*DW +: DW]),
      .pos_o     (pos_w[c*DW +: DW]),
      .sat_o     (sat[c])
    );
  end

  assign bus.pos         = pos_w;
  assign bus.store_valid = (state_q == S_HDR) || (state_q == S_DATA);
  assign bus.store_kind  = (state_q == S_HDR) ? STORE_HDR : STORE_DATA;
  assign options         = opt_q;
  assign section         = sec_q;
  assign finished        = (state_q == S_DONE);
  assign prog_err        = prog_err_q;
endmodule

// File: tb/tb_gvp_ng.sv
// Self-checking bench for gvp_ng against a section-level behavioural model.
module tb_gvp_ng;
  localparam int NCH = 4;
  localparam int N2  = 3;
  localparam int DW  = 32;
  localparam int PW  = 160 + NCH * DW;
  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINP = -64'sd2147483648;

  logic a_clk = 1'b0, a_resetn = 1'b1, run = 1'b0, pause = 1'b0, pos_clr = 1'b0;
  logic [31:0] options, section;
  logic busy, finished, prog_err;
  logic [NCH-1:0] sat;

  gvp_ng_if #(.NUM_CH(NCH), .NUM_VECTORS_N2(N2), .DW(DW)) bus ();

  gvp_ng #(.NUM_CH(NCH), .NUM_VECTORS_N2(N2), .DW(DW)) dut (
    .a_clk(a_clk), .a_resetn(a_resetn), .bus(bus), .run(run), .pause(pause),
    .pos_clr(pos_clr), .options(options), .section(section), .busy(busy),
    .finished(finished), .prog_err(prog_err), .sat(sat)
  );

  always #5 a_clk = ~a_clk;

  int checks = 0, errors = 0;

  int m_n[8], m_iin[8], m_deci[8], m_opt[8], m_nrep[8], m_next[8];
  int m_delta[8][4];
  int exp_pos[4];
  int exp_sec, exp_opt;
  logic [3:0] exp_sat;
  logic [128:0] q_exp[$];

  function automatic logic [127:0] pack_pos();
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[c*32 +: 32] = exp_pos[c];
    return r;
  endfunction

  // Walks the program section by section with plain saturating integer maths.
  task automatic model_run();
    int pvc;
    int lc[8];
    longint s;
    pvc = 0; q_exp.delete(); exp_sec = 0; exp_sat = '0;
    for (int v = 0; v < 8; v++) lc[v] = m_nrep[v];
    for (int g = 0; g < 64; g++) begin
      exp_opt = m_opt[pvc];
      if (m_n[pvc] == 0) break;
      q_exp.push_back({1'b1, pack_pos()});
      for (int k = 0; k < m_n[pvc]; k++) begin
        for (int t = 0; t <= m_iin[pvc]; t++)
          for (int c = 0; c < 4; c++) begin
            s = longint'(exp_pos[c]) + longint'(m_delta[pvc][c]);
            if (s > MAXP) begin s = MAXP; exp_sat[c] = 1'b1; end
            else if (s < MINP) begin s = MINP; exp_sat[c] = 1'b1; end
            exp_pos[c] = int'(s);
          end
        q_exp.push_back({1'b0, pack_pos()});
      end
      exp_sec++;
      if (lc[pvc] > 0) begin lc[pvc] = lc[pvc] - 1; pvc = (pvc + m_next[pvc]) & 7; end
      else begin lc[pvc] = m_nrep[pvc]; pvc = (pvc + 1) & 7; end
    end
  endtask

  task automatic set_vec(input int a, input int n, input int iin, input int deci,
                         input int opt, input int nrep, input int nxt,
                         input int d0, input int d1, input int d2, input int d3);
    logic [PW-1:0] pd;
    m_n[a] = n; m_iin[a] = iin; m_deci[a] = deci; m_opt[a] = opt;
    m_nrep[a] = nrep; m_next[a] = nxt;
    m_delta[a][0] = d0; m_delta[a][1] = d1; m_delta[a][2] = d2; m_delta[a][3] = d3;
    pd = '0;
    pd[31:0] = n; pd[63:32] = iin; pd[95:64] = deci; pd[127:96] = opt;
    pd[143:128] = nrep[15:0]; pd[151:144] = nxt[7:0];
    pd[160 +: 32] = d0; pd[192 +: 32] = d1; pd[224 +: 32] = d2; pd[256 +: 32] = d3;
    @(negedge a_clk);
    bus.prog_addr = a[2:0]; bus.prog_data = pd; bus.prog_we = 1'b1;
    @(negedge a_clk);
    bus.prog_we = 1'b0;
  endtask

  task automatic clear_pos();
    @(negedge a_clk); pos_clr = 1'b1;
    @(negedge a_clk); pos_clr = 1'b0;
    for (int c = 0; c < 4; c++) exp_pos[c] = 0;
  endtask

  task automatic run_prog(input string name, input bit rnd);
    logic [128:0] e;
    bit done;
    int idx;
    model_run();
    run = 1'b1; bus.store_ready = 1'b1; done = 1'b0; idx = 0;
    for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
      @(negedge a_clk);
      if (finished === 1'b1) done = 1'b1;
      else begin
        if (rnd) begin
          bus.store_ready = ($urandom_range(0, 2) != 0);
          pause = ($urandom_range(0, 3) == 0);
        end
        if (bus.store_valid === 1'b1 && bus.store_ready === 1'b1) begin
          checks++;
          if (q_exp.size() == 0) begin
            errors++;
            $display("FAIL %s extra_store %0d: got kind=%0b pos=%h, required no store", name, idx, bus.store_kind, bus.pos);
          end else begin
            e = q_exp.pop_front();
            if ({bus.store_kind, bus.pos} !== e) begin
              errors++;
              $display("FAIL %s store %0d: got kind=%0b pos=%h, required kind=%0b pos=%h", name, idx, bus.store_kind, bus.pos, e[128], e[127:0]);
            end
          end
          idx++;
        end
      end
    end
    pause = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL %s finish_timeout: finished=%0b, required 1", name, finished); end
    checks++;
    if (q_exp.size() != 0) begin errors++; $display("FAIL %s missing_stores: got %0d short, required 0", name, q_exp.size()); end
    checks++;
    if (section !== exp_sec) begin errors++; $display("FAIL %s section: got %0d, required %0d", name, section, exp_sec); end
    checks++;
    if (sat !== exp_sat) begin errors++; $display("FAIL %s sat: got %b, required %b", name, sat, exp_sat); end
    checks++;
    if (options !== exp_opt) begin errors++; $display("FAIL %s options: got %h, required %h", name, options, exp_opt); end
    checks++;
    if (bus.pos !== pack_pos()) begin errors++; $display("FAIL %s final_pos: got %h, required %h", name, bus.pos, pack_pos()); end
    run = 1'b0;
    @(negedge a_clk);
    checks++;
    if (busy !== 1'b0 || finished !== 1'b0) begin
      errors++; $display("FAIL %s idle_after_run: got busy=%0b finished=%0b, required 0 0", name, busy, finished);
    end
  endtask

  task automatic test_reset();
    #3 a_resetn = 1'b0;
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if ({bus.store_valid, bus.store_kind, busy, finished, prog_err} !== 5'b0) begin
        errors++; $display("FAIL reset_flags[%0d]: got %b, required 00000", pass, {bus.store_valid, bus.store_kind, busy, finished, prog_err});
      end
      checks++;
      if (bus.pos !== '0 || section !== '0 || options !== '0 || sat !== '0) begin
        errors++; $display("FAIL reset_regs[%0d]: got pos=%h section=%h options=%h sat=%b, required all 0", pass, bus.pos, section, options, sat);
      end
      if (pass == 0) begin
        repeat (2) @(negedge a_clk);
        a_resetn = 1'b1;
        @(negedge a_clk);
      end
    end
    for (int c = 0; c < 4; c++) exp_pos[c] = 0;
  endtask

  task automatic test_basic();
    set_vec(0, 3, 1, 1, 32'h11, 0, 0, 5, 0, 0, 0);
    set_vec(1, 0, 0, 0, 32'h22, 0, 0, 0, 0, 0, 0);
    clear_pos();
    run_prog("basic", 1'b0);
    checks++;
    if (bus.pos[31:0] !== 32'd30 || section !== 32'd1) begin
      errors++; $display("FAIL basic_const: got pos0=%0d section=%0d, required 30 1", bus.pos[31:0], section);
    end
  endtask

  task automatic test_loop();
    set_vec(0, 2, 0, 1, 32'h5, 2, 0, 1, 0, 0, 0);
    set_vec(1, 0, 0, 0, 32'h6, 0, 0, 0, 0, 0, 0);
    clear_pos();
    run_prog("loop", 1'b0);
    checks++;
    if (bus.pos[31:0] !== 32'd6 || section !== 32'd3) begin
      errors++; $display("FAIL loop_const: got pos0=%0d section=%0d, required 6 3", bus.pos[31:0], section);
    end
  endtask

  task automatic test_sat();
    set_vec(0, 2, 0, 1, 32'h7, 0, 0, 32'h7FFF_FFF0, int'(32'h8000_0010), 3, 0);
    set_vec(1, 0, 0, 0, 32'h8, 0, 0, 0, 0, 0, 0);
    clear_pos();
    run_prog("sat", 1'b0);
    checks++;
    if (bus.pos[31:0] !== 32'h7FFF_FFFF || bus.pos[63:32] !== 32'h8000_0000 || sat !== 4'b0011) begin
      errors++; $display("FAIL sat_const: got pos0=%h pos1=%h sat=%b, required 7fffffff 80000000 0011", bus.pos[31:0], bus.pos[63:32], sat);
    end
  endtask

  task automatic test_deci_backpressure();
    int first, gap, nchg;
    logic [31:0] prev;
    bit seen, stable;
    set_vec(0, 1, 1, 4, 32'h33, 0, 0, 3, 0, 0, 0);
    set_vec(1, 0, 0, 0, 32'h44, 0, 0, 0, 0, 0, 0);
    clear_pos();
    model_run();
    bus.store_ready = 1'b0; run = 1'b1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge a_clk);
      seen = (bus.store_valid === 1'b1 && bus.store_kind === 1'b1);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL deci_hdr_wait: got no header, required header"); end
    bus.store_ready = 1'b1;
    @(negedge a_clk);
    bus.store_ready = 1'b0;
    prev = bus.pos[31:0]; nchg = 0; first = 0; gap = 0; seen = 1'b0;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge a_clk);
      if (bus.pos[31:0] !== prev) begin
        if (nchg == 0) first = cyc; else gap = cyc - first;
        nchg++;
        prev = bus.pos[31:0];
      end
      seen = (bus.store_valid === 1'b1 && bus.store_kind === 1'b0);
    end
    checks++;
    if (!seen || nchg != 2 || first != 4 || gap != 4) begin
      errors++; $display("FAIL deci_spacing: got data=%0b adds=%0d first=%0d gap=%0d, required 1 2 4 4", seen, nchg, first, gap);
    end
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge a_clk);
      if (!(bus.store_valid === 1'b1 && bus.store_kind === 1'b0 && bus.pos[31:0] === prev)) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL backpressure_stable: got valid=%0b pos0=%0d, required 1 %0d", bus.store_valid, bus.pos[31:0], prev); end
    bus.store_ready = 1'b1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge a_clk);
      seen = (finished === 1'b1);
    end
    checks++;
    if (!seen || bus.pos[31:0] !== 32'd6 || section !== 32'd1) begin
      errors++; $display("FAIL backpressure_advance: got finished=%0b pos0=%0d section=%0d, required 1 6 1", finished, bus.pos[31:0], section);
    end
    run = 1'b0;
    @(negedge a_clk);
  endtask

  task automatic test_pause();
    bit seen, stable;
    set_vec(0, 2, 0, 1, 32'h55, 0, 0, 7, 0, 0, 0);
    set_vec(1, 0, 0, 0, 32'h66, 0, 0, 0, 0, 0, 0);
    clear_pos();
    pause = 1'b1; bus.store_ready = 1'b1; run = 1'b1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge a_clk);
      seen = (bus.store_valid === 1'b1 && bus.store_kind === 1'b1);
    end
    @(negedge a_clk);
    stable = seen;
    for (int k = 0; k < 5; k++) begin
      @(negedge a_clk);
      if (bus.pos[31:0] !== 32'd0 || bus.store_valid !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin errors++; $display("FAIL pause_hold: got pos0=%0d valid=%0b, required 0 0", bus.pos[31:0], bus.store_valid); end
    pause = 1'b0; seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge a_clk);
      seen = (bus.store_valid === 1'b1);
    end
    checks++;
    if (!seen || bus.store_kind !== 1'b0 || bus.pos[31:0] !== 32'd7) begin
      errors++; $display("FAIL pause_release: got valid=%0b kind=%0b pos0=%0d, required 1 0 7", seen, bus.store_kind, bus.pos[31:0]);
    end
    pause = 1'b1;
    repeat (2) @(negedge a_clk);
    checks++;
    if (busy !== 1'b1 || bus.store_valid !== 1'b0) begin
      errors++; $display("FAIL pause_step: got busy=%0b valid=%0b, required 1 0", busy, bus.store_valid);
    end
    run = 1'b0;
    @(negedge a_clk);
    checks++;
    if (busy !== 1'b0 || bus.store_valid !== 1'b0 || finished !== 1'b0 || bus.pos[31:0] !== 32'd7 || section !== 32'd0) begin
      errors++; $display("FAIL run_abort: got busy=%0b valid=%0b fin=%0b pos0=%0d section=%0d, required 0 0 0 7 0", busy, bus.store_valid, finished, bus.pos[31:0], section);
    end
    pause = 1'b0;
    for (int c = 0; c < 4; c++) exp_pos[c] = 0;
    exp_pos[0] = 7;
  endtask

  task automatic test_prog_err();
    bit seen;
    set_vec(0, 1, 0, 1, 32'h77, 0, 0, 2, 0, 0, 0);
    set_vec(1, 0, 0, 0, 32'h88, 0, 0, 0, 0, 0, 0);
    clear_pos();
    pause = 1'b1; bus.store_ready = 1'b1; run = 1'b1;
    repeat (6) @(negedge a_clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL prog_err_busy: got busy=%0b, required 1", busy); end
    bus.prog_addr = '0; bus.prog_data = '1; bus.prog_we = 1'b1;
    @(negedge a_clk);
    bus.prog_we = 1'b0;
    checks++;
    if (prog_err !== 1'b1) begin errors++; $display("FAIL prog_err_pulse: got %0b, required 1", prog_err); end
    @(negedge a_clk);
    checks++;
    if (prog_err !== 1'b0) begin errors++; $display("FAIL prog_err_clear: got %0b, required 0", prog_err); end
    pause = 1'b0; run = 1'b0;
    @(negedge a_clk);
    clear_pos();
    run_prog("mem_kept", 1'b0);
    checks++;
    if (bus.pos[31:0] !== 32'd2) begin errors++; $display("FAIL mem_kept_const: got pos0=%0d, required 2", bus.pos[31:0]); end
    bus.store_ready = 1'b1; run = 1'b1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge a_clk);
      seen = (bus.store_valid === 1'b1 && bus.store_kind === 1'b0);
    end
    bus.store_ready = 1'b0;
    #2 a_resetn = 1'b0;
    #1;
    checks++;
    if (!seen || {bus.store_valid, bus.store_kind, busy, finished, prog_err} !== 5'b0 ||
        bus.pos !== '0 || section !== '0 || options !== '0 || sat !== '0) begin
      errors++; $display("FAIL reset_mid_data: got data=%0b flags=%b pos=%h section=%0d options=%h sat=%b, required 1 00000 0 0 0 0",
                         seen, {bus.store_valid, bus.store_kind, busy, finished, prog_err}, bus.pos, section, options, sat);
    end
    run = 1'b0;
    @(negedge a_clk);
    a_resetn = 1'b1;
    @(negedge a_clk);
    for (int c = 0; c < 4; c++) exp_pos[c] = 0;
  endtask

  task automatic test_random();
    int k, d[4];
    for (int it = 0; it < 4; it++) begin
      k = int'($urandom_range(1, 3));
      for (int v = 0; v < k; v++) begin
        for (int c = 0; c < 4; c++)
          d[c] = ($urandom_range(0, 3) == 0) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
        set_vec(v, int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom), int'($urandom_range(0, 2)), 0, d[0], d[1], d[2], d[3]);
      end
      set_vec(k, 0, 0, 0, int'($urandom), 0, 0, 0, 0, 0, 0);
      run_prog("random", 1'b1);
    end
    set_vec(0, 1, 0, 2, 32'h1, 0, 0, 9, -4, 0, 1);
    set_vec(1, 1, 1, 1, 32'h2, 1, -1, -3, 2, 5, 1);
    set_vec(2, 0, 0, 0, 32'h3, 0, 0, 0, 0, 0, 0);
    run_prog("jump_back", 1'b1);
  endtask

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0; bus.store_ready = 1'b0;
    test_reset();
    test_basic();
    test_loop();
    test_sat();
    test_deci_backpressure();
    test_pause();
    test_prog_err();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
